mdu_hilo: RTL and testbench

- Iterative multiply/divide unit that owns the architectural HI/LO register pair.
- Sits beside the combinational ALU in the execute stage. Executes MULT/MULTU/DIV/DIVU over multiple cycles and handles MTHI/MTLO writes.
- The pipeline reads hi/lo for MFHI/MFLO and must stall while busy is high.

---
 rtl/mdu_pkg.sv | 20 ++
 rtl/mdu_divstep.sv | 27 ++
 rtl/mdu_hilo.sv | 185 ++++++++++++++++++
 tb/tb_mdu_hilo.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states,
// and the default operand width.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/mdu_divstep.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor if it fits.
module mdu_divstep
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dbit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             qbit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Trial subtraction; a clear borrow bit means the divisor fits. When it
  // does not fit the shifted value is below the divisor, so it fits in WIDTH bits.
  always_comb begin
    shifted = {rem_in, dbit};
    diff    = shifted - {1'b0, divisor};
    qbit    = ~diff[WIDTH];
    rem_out = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit owning the HI/LO pair. Operations run on
// unsigned magnitudes for WIDTH cycles, then a single fix-up cycle applies
// signs and writes HI/LO.
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  // Multiply: {partial high, multiplier shifting out}.
  // Divide:   {partial remainder, dividend shifting out / quotient shifting in}.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;       // multiplicand or divisor magnitude
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;       // product/quotient must be negated
  logic               rem_neg_q, rem_neg_d;
  logic               dzero_q, dzero_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;

  logic               signed_op;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] div_next;
  logic [WIDTH-1:0]   div_rem;
  logic               div_qbit;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  mdu_divstep #(.WIDTH(WIDTH)) u_divstep (
    .rem_in  (acc_q[2*WIDTH-1:WIDTH]),
    .dbit    (acc_q[WIDTH-1]),
    .divisor (opb_q),
    .rem_out (div_rem),
    .qbit    (div_qbit)
  );

  // Operand magnitudes, per-cycle step results and sign-corrected results.
  always_comb begin
    signed_op = (op == OP_MULT) || (op == OP_DIV);
    a_neg     = signed_op & in0[WIDTH-1];
    b_neg     = signed_op & in1[WIDTH-1];
    mag_a     = a_neg ? -in0 : in0;
    mag_b     = b_neg ? -in1 : in1;

    // Shift-add: add the multiplicand into the high half when the current
    // multiplier bit is set, then shift the whole accumulator right.
    if (acc_q[0]) begin
      mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q};
    end else begin
      mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    end
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    div_next = {div_rem, acc_q[WIDTH-2:0], div_qbit};

    prod_fix = neg_q ? -acc_q : acc_q;
    quot_fix = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  // Next-state logic for the FSM, datapath and HI/LO registers.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    dzero_d   = dzero_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dz_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              state_d   = ST_RUN;
              cnt_d     = '0;
              is_div_d  = op[1];
              neg_d     = a_neg ^ b_neg;
              rem_neg_d = a_neg;
              dzero_d   = op[1] && (in1 == '0);
              if (op[1]) begin
                acc_d = {{WIDTH{1'b0}}, mag_a};
                opb_d = mag_b;
              end else begin
                acc_d = {{WIDTH{1'b0}}, mag_b};
                opb_d = mag_a;
              end
            end
            OP_MTHI: hi_d = in0;
            OP_MTLO: lo_d = in0;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        // With a zero divisor every step subtracts nothing, so the remainder
        // is the dividend magnitude and rem_fix restores the original dividend.
        if (is_div_q) begin
          lo_d = dzero_q ? {WIDTH{1'b1}} : quot_fix;
          hi_d = rem_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        dz_d    = is_div_q & dzero_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset drops any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dzero_q   <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      dzero_q   <= dzero_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign dz   = dz_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed testbench for mdu_hilo: arithmetic results, latency, busy
// behaviour, divide-by-zero, HI/LO moves and asynchronous reset.
module tb_mdu_hilo;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] in0;
  logic [31:0] in1;
  logic        busy;
  logic        done;
  logic        dz;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  int cyc;
  int ndone;

  mdu_hilo #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .in0   (in0),
    .in1   (in1),
    .busy  (busy),
    .done  (done),
    .dz    (dz),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request for one edge, then scramble operands to show they are not reused.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    in0   = a;
    in1   = b;
    @(negedge clk);
    start = 1'b0;
    in0   = 32'hA5A5A5A5;
    in1   = 32'h5A5A5A5A;
  endtask

  // Called at the negedge after the accepting edge; returns at the done-cycle negedge.
  task automatic wait_done(input string tag);
    check({tag, "_busy_on"}, {31'b0, busy}, 32'd1);
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, cyc, 32'd33);
    check({tag, "_done"}, {31'b0, done}, 32'd1);
  endtask

  task automatic show(input string tag);
    $display("%s: hi=%h lo=%h done=%0b dz=%0b busy=%0b", tag, hi, lo, done, dz, busy);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    op    = 3'b000;
    in0   = '0;
    in1   = '0;
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_dz", {31'b0, dz}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // MULT -3 * 5.
    issue(3'b000, 32'hFFFFFFFD, 32'd5);
    wait_done("mult");
    show("MULT -3*5");
    check("mult_hi", hi, 32'hFFFFFFFF);
    check("mult_lo", lo, 32'hFFFFFFF1);
    check("mult_dz", {31'b0, dz}, 32'd0);
    check("mult_busy_done", {31'b0, busy}, 32'd0);
    @(negedge clk);
    check("mult_done_pulse", {31'b0, done}, 32'd0);

    // MULTU max*max with MTLO and MULT requests thrown in while busy.
    issue(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (4) @(negedge clk);
    issue(3'b101, 32'h55555555, 32'h0);
    check("multu_mtlo_ignored", lo, 32'hFFFFFFF1);
    repeat (3) @(negedge clk);
    issue(3'b000, 32'd2, 32'd3);
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("multu_done", {31'b0, done}, 32'd1);
    show("MULTU max*max");
    check("multu_hi", hi, 32'hFFFFFFFE);
    check("multu_lo", lo, 32'h00000001);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    check("multu_no_extra_done", ndone, 32'd0);
    check("multu_idle_after", {31'b0, busy}, 32'd0);

    // DIV -7 / 2.
    issue(3'b010, 32'hFFFFFFF9, 32'd2);
    wait_done("div");
    show("DIV -7/2");
    check("div_lo", lo, 32'hFFFFFFFD);
    check("div_hi", hi, 32'hFFFFFFFF);
    check("div_dz", {31'b0, dz}, 32'd0);
    @(negedge clk);

    // DIV signed overflow.
    issue(3'b010, 32'h80000000, 32'hFFFFFFFF);
    wait_done("divov");
    show("DIV min/-1");
    check("divov_lo", lo, 32'h80000000);
    check("divov_hi", hi, 32'h00000000);
    check("divov_dz", {31'b0, dz}, 32'd0);
    @(negedge clk);

    // DIVU by zero, then a back-to-back DIVU issued in the done cycle.
    issue(3'b011, 32'd100, 32'd0);
    wait_done("divz");
    show("DIVU 100/0");
    check("divz_hi", hi, 32'd100);
    check("divz_lo", lo, 32'hFFFFFFFF);
    check("divz_dz", {31'b0, dz}, 32'd1);
    issue(3'b011, 32'd1000, 32'd7);
    check("divz_dz_clear", {31'b0, dz}, 32'd0);
    wait_done("divu");
    show("DIVU 1000/7");
    check("divu_lo", lo, 32'd142);
    check("divu_hi", hi, 32'd6);
    @(negedge clk);

    // MTHI then MTLO on consecutive cycles.
    start = 1'b1;
    op    = 3'b100;
    in0   = 32'h12345678;
    @(negedge clk);
    check("mthi_hi", hi, 32'h12345678);
    check("mthi_lo", lo, 32'd142);
    check("mthi_busy", {31'b0, busy}, 32'd0);
    check("mthi_done", {31'b0, done}, 32'd0);
    op  = 3'b101;
    in0 = 32'h9ABCDEF0;
    @(negedge clk);
    start = 1'b0;
    show("MTHI/MTLO");
    check("mtlo_lo", lo, 32'h9ABCDEF0);
    check("mtlo_hi", hi, 32'h12345678);
    check("mtlo_busy", {31'b0, busy}, 32'd0);
    check("mtlo_done", {31'b0, done}, 32'd0);

    // Reserved op is ignored.
    issue(3'b110, 32'hDEADBEEF, 32'd1);
    check("rsvd_busy", {31'b0, busy}, 32'd0);
    check("rsvd_hi", hi, 32'h12345678);

    // Reset in the middle of a DIVU.
    issue(3'b011, 32'd1000, 32'd7);
    repeat (9) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    show("async reset");
    check("arst_hi", hi, 32'h0);
    check("arst_lo", lo, 32'h0);
    check("arst_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    check("arst_no_done", ndone, 32'd0);
    check("arst_hi_after", hi, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
